synapse_array: RTL and testbench
================================

Name: synapse_array

Overview:
- Parametrised N-channel successor to the single synapse; one instance feeds a full neuron fan-in.
- Per channel: an internally stored weight, and an accumulator that integrates incoming spikes scaled by that weight.
- Two output modes: windowed rate mode and continuous integrate-and-fire mode.
- Weights are loaded through a write port. All channels share one window counter and one threshold.

Parameters:
- N_CH, 8: number of synapse channels (1..64).
- WINDOW, 16: spiking window length in cycles (2..256).
- ACC_W, 16: accumulator width in bits, unsigned, saturating.
- ADDR_W, $clog2(N_CH) (minimum 1): weight write address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; when low, counter, accumulators and outputs hold
- mode  in  1  0 = window (rate) mode, 1 = integrate-and-fire mode
- pre_spike  in  N_CH  incoming spike per channel
- threshold  in  ACC_W  shared firing threshold, unsigned
- wt_wr_en  in  1  weight write strobe
- wt_wr_addr  in  ADDR_W  channel to write
- wt_wr_data  in  WEIGHT_W (weight_t)  new weight, unsigned
- weighted_spike  out  N_CH  output spike per channel, registered
- window_done  out  1  one-cycle pulse on the last window cycle (either mode)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset clears all weights, accumulators, the window counter, weighted_spike and window_done to 0.
- Window counter:
  - Width $clog2(WINDOW).
  - When en=1, it increments 0..WINDOW-1 and wraps to 0.
  - window_done is registered: it goes 1 in the cycle after the counter held WINDOW-1 with en=1.
- Accumulate: on a cycle with en=1 and pre_spike[i]=1, acc_i += weight_i, saturating at 2^ACC_W-1. The weight is zero-extended.
- Mode 0 (window):
  - Let final_i = acc_i plus the current-cycle contribution on the counter==WINDOW-1 cycle.
  - On that cycle: weighted_spike[i] <= (final_i > threshold), and acc_i <= 0.
  - On all other en cycles, weighted_spike[i] <= 0. Result: at most one pulse per window, aligned with window_done.
- Mode 1 (integrate-and-fire):
  - Each en cycle, sum_i = acc_i + contribution (saturated).
  - If sum_i > threshold: weighted_spike[i] <= 1 and acc_i <= sum_i - threshold (subtractive reset). Otherwise weighted_spike[i] <= 0 and acc_i <= sum_i.
  - The window counter still runs, but window boundaries do not clear acc_i.
- Comparison is strict (>). Equality does not fire.
- Latency: a spike input affects weighted_spike exactly 1 cycle later (mode 1), or on the window-end cycle + 1 (mode 0).
- en=0: all state holds, weighted_spike and window_done drive 0, and weight writes still complete.
- Weight write:
  - When wt_wr_en=1 and wt_wr_addr < N_CH, weight[addr] <= wt_wr_data at the next edge.
  - An out-of-range address is ignored.
  - If a write and a spike hit the same channel in the same cycle, the old weight is used for that spike.
- Mode change:
  - A mode change takes effect on the next edge.
  - Any mode change (detected against a registered copy of mode) clears all accumulators and the window counter in that cycle. Spikes arriving in that cycle are dropped.
- threshold is sampled every cycle and has no internal register. Software changes it only while en=0.

Decomposition:
- neuron_pkg contains:
  - weight_t: existing type, WEIGHT_W unsigned.
  - MODE_WINDOW / MODE_IAF: localparams.
  - sat_add function: a saturating add of weight into ACC_W.
- Sub-module synapse_channel holds one channel's weight register, accumulator, compare and output flop.
- synapse_array instantiates N_CH channels in a generate loop. It also contains the shared window counter, write-address decode, mode-change detect and window_done.

Test Plan:
1. Reset check: reset mid-window (counter=7, acc=30) -> all outputs 0 immediately, weights 0; after release, the first window_done arrives exactly 16 en-cycles later.
2. Mode 0, WINDOW=16, weight[0]=3, threshold=20: 7 spikes -> acc=21 -> weighted_spike[0]=1 for one cycle with window_done. 6 spikes (acc 18) -> no pulse. Exactly 20 -> no pulse (strict compare).
3. Mode 1, weight[2]=5, threshold=12, spike every cycle:
   - acc sequence is 5, 10, 15→3 (fire), 8, 13→1 (fire).
   - Required: weighted_spike[2] pattern 0,0,1,0,1 one cycle after the corresponding inputs.
4. Saturation: ACC_W=8, weight=255, threshold=254, mode 0, 16 spikes -> acc holds at 255 (no wrap) -> fires at window end.
5. Weight write collision: write weight[1]=9 in the same cycle as a spike on channel 1 (old weight 2) -> acc +2 that cycle, +9 on the next spike. A write to addr=N_CH leaves all weights unchanged.
6. Enable and mode switch:
   - Deassert en for 5 cycles mid-window -> counter and acc freeze and window_done is delayed by exactly 5 cycles.
   - Toggle mode mid-window -> all acc=0, counter=0, no spurious weighted_spike.

Source files
------------

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the spiking synapse/neuron blocks.
package neuron_pkg;

  localparam int unsigned WEIGHT_W = 8;
  localparam int unsigned SAT_W    = 32;

  typedef logic [WEIGHT_W-1:0] weight_t;

  localparam logic MODE_WINDOW = 1'b0;
  localparam logic MODE_IAF    = 1'b1;

  // Add a zero-extended weight to an accumulator, clamping at 2^acc_w-1.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] acc,
                                                input weight_t           w,
                                                input int unsigned       acc_w);
    logic [SAT_W:0] sum;
    logic [SAT_W:0] lim;
    sum = {1'b0, acc} + 33'(w);
    lim = (33'(1) << acc_w) - 33'(1);
    return (sum > lim) ? lim[SAT_W-1:0] : sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/synapse_array_if.sv
// Control, weight-write and spike bus of the synapse array.
interface synapse_array_if #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned ADDR_W = 3
);
  import neuron_pkg::*;

  logic              en;
  logic              mode;
  logic [N_CH-1:0]   pre_spike;
  logic [ACC_W-1:0]  threshold;
  logic              wt_wr_en;
  logic [ADDR_W-1:0] wt_wr_addr;
  weight_t           wt_wr_data;
  logic [N_CH-1:0]   weighted_spike;
  logic              window_done;

  modport master (
    output en, mode, pre_spike, threshold, wt_wr_en, wt_wr_addr, wt_wr_data,
    input  weighted_spike, window_done
  );

  modport slave (
    input  en, mode, pre_spike, threshold, wt_wr_en, wt_wr_addr, wt_wr_data,
    output weighted_spike, window_done
  );
endinterface

// File: rtl/synapse_channel.sv
// One synapse: weight register, saturating accumulator, threshold compare and output flop.
module synapse_channel
  import neuron_pkg::*;
#(
  parameter int unsigned ACC_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             mode_chg,
  input  logic             last,
  input  logic             spike,
  input  logic [ACC_W-1:0] threshold,
  input  logic             wr_en,
  input  weight_t          wr_data,
  output logic             weighted_spike
);

  weight_t          weight_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum_c;
  logic             spike_d;

  // The spike always sees the weight held before any same-cycle write.
  assign sum_c = ACC_W'(sat_add(32'(acc_q), spike ? weight_q : weight_t'(0), ACC_W));

  // Next accumulator and output spike for both modes.
  always_comb begin
    acc_d   = acc_q;
    spike_d = 1'b0;
    if (mode_chg) begin
      acc_d = '0;
    end else if (en) begin
      if (mode == MODE_WINDOW) begin
        if (last) begin
          spike_d = (sum_c > threshold);
          acc_d   = '0;
        end else begin
          acc_d = sum_c;
        end
      end else if (sum_c > threshold) begin
        spike_d = 1'b1;
        acc_d   = sum_c - threshold;
      end else begin
        acc_d = sum_c;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q       <= '0;
      acc_q          <= '0;
      weighted_spike <= 1'b0;
    end else begin
      if (wr_en) weight_q <= wr_data;
      acc_q          <= acc_d;
      weighted_spike <= spike_d;
    end
  end

endmodule

// File: rtl/synapse_array.sv
// N-channel synapse array with shared window counter, threshold and weight write port.
module synapse_array #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned WINDOW = 16,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned ADDR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  synapse_array_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WINDOW);

  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic             done_q;
  logic             mode_chg_c;
  logic             last_c;
  logic [N_CH-1:0]  spike_vec;

  assign mode_chg_c = (bus.mode != mode_q);
  assign last_c     = (cnt_q == CNT_W'(WINDOW - 1));

  // Shared window counter; a mode change restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      mode_q <= bus.mode;
      done_q <= bus.en & last_c & ~mode_chg_c;
      if (mode_chg_c) begin
        cnt_q <= '0;
      end else if (bus.en) begin
        cnt_q <= last_c ? '0 : cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    synapse_channel #(
      .ACC_W (ACC_W)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (bus.en),
      .mode           (bus.mode),
      .mode_chg       (mode_chg_c),
      .last           (last_c),
      .spike          (bus.pre_spike[i]),
      .threshold      (bus.threshold),
      .wr_en          (bus.wt_wr_en && (bus.wt_wr_addr == ADDR_W'(i))),
      .wr_data        (bus.wt_wr_data),
      .weighted_spike (spike_vec[i])
    );
  end

  assign bus.weighted_spike = spike_vec;
  assign bus.window_done    = done_q;

endmodule

// File: tb/tb_synapse_array.sv
// Scoreboard bench for synapse_array: per-cycle reference model plus directed scenario checks.
module tb_synapse_array;
  import neuron_pkg::*;

  localparam int N    = 6;
  localparam int WIN  = 16;
  localparam int AW   = 16;
  localparam int ADW  = 3;
  localparam int MAXV = 65535;

  typedef struct packed {
    logic [N-1:0] ws;
    logic         wd;
  } exp_t;

  logic clk;
  logic rst_n;

  synapse_array_if #(.N_CH(N), .ACC_W(AW), .ADDR_W(ADW)) bus ();
  synapse_array #(.N_CH(N), .WINDOW(WIN), .ACC_W(AW), .ADDR_W(ADW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  synapse_array_if #(.N_CH(2), .ACC_W(8), .ADDR_W(1)) bus8 ();
  synapse_array #(.N_CH(2), .WINDOW(16), .ACC_W(8), .ADDR_W(1)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  int           checks;
  int           errors;
  int           m_w   [N];
  int           m_acc [N];
  int           m_cnt;
  logic         m_mode_q;
  exp_t         sb[$];
  logic [2:0]   sb8[$];
  logic [N-1:0] obs_ws;
  logic         obs_wd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_w[i]   = 0;
      m_acc[i] = 0;
    end
    m_cnt    = 0;
    m_mode_q = 1'b0;
  endtask

  // Drive one clock of stimulus, push the model's expectation, then compare after the edge.
  task automatic cycle(input logic [N-1:0] sp);
    exp_t e;
    logic chg;
    logic last;
    int   s;
    int   thr;
    chg  = (bus.mode !== m_mode_q);
    last = (m_cnt == WIN - 1);
    thr  = int'(bus.threshold);
    e.ws = '0;
    for (int i = 0; i < N; i++) begin
      s = m_acc[i] + (sp[i] ? m_w[i] : 0);
      if (s > MAXV) s = MAXV;
      if (chg) begin
        m_acc[i] = 0;
      end else if (bus.en) begin
        if (bus.mode == MODE_WINDOW) begin
          if (last) begin
            e.ws[i]  = (s > thr);
            m_acc[i] = 0;
          end else begin
            m_acc[i] = s;
          end
        end else if (s > thr) begin
          e.ws[i]  = 1'b1;
          m_acc[i] = s - thr;
        end else begin
          m_acc[i] = s;
        end
      end
    end
    e.wd = bus.en && last && !chg;
    if (chg) m_cnt = 0;
    else if (bus.en) m_cnt = last ? 0 : m_cnt + 1;
    if (bus.wt_wr_en && int'(bus.wt_wr_addr) < N) m_w[int'(bus.wt_wr_addr)] = int'(bus.wt_wr_data);
    m_mode_q = bus.mode;
    bus.pre_spike = sp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e      = sb.pop_front();
    obs_ws = bus.weighted_spike;
    obs_wd = bus.window_done;
    checks++;
    if (obs_ws !== e.ws || obs_wd !== e.wd) begin
      errors++;
      $display("FAIL cycle t=%0t weighted_spike=%b exp=%b window_done=%b exp=%b",
               $time, obs_ws, e.ws, obs_wd, e.wd);
    end
  endtask

  task automatic wr(input int addr, input int data);
    bus.en         = 1'b0;
    bus.wt_wr_en   = 1'b1;
    bus.wt_wr_addr = ADW'(addr);
    bus.wt_wr_data = weight_t'(data);
    cycle('0);
    bus.wt_wr_en   = 1'b0;
  endtask

  task automatic run_window(input int nspk);
    for (int k = 0; k < WIN; k++) cycle((k < nspk) ? N'(1) : N'(0));
  endtask

  task automatic test_reset();
    int found;
    checks++;
    if (bus.weighted_spike !== '0 || bus.window_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial ws=%b wd=%b exp 0", bus.weighted_spike, bus.window_done);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    wr(0, 5);
    bus.en = 1'b1;
    for (int k = 0; k < 7; k++) cycle((k < 6) ? N'(1) : N'(0));
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.weighted_spike !== '0 || bus.window_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_midwindow ws=%b wd=%b exp 0", bus.weighted_spike, bus.window_done);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle(N'(1));
      if (obs_wd) begin
        found = k;
        break;
      end
    end
    checks++;
    if (found != 16) begin
      errors++;
      $display("FAIL reset_first_done cycles=%0d exp 16", found);
    end
    checks++;
    if (obs_ws[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_weight_cleared ws0=%b exp 0", obs_ws[0]);
    end
  endtask

  task automatic test_window_mode();
    int nspk [3] = '{7, 6, 5};
    logic expv [3] = '{1'b1, 1'b0, 1'b0};
    bus.threshold = AW'(20);
    wr(0, 3);
    for (int t = 0; t < 3; t++) begin
      if (t == 2) wr(0, 4);
      bus.en = 1'b1;
      run_window(nspk[t]);
      checks++;
      if (obs_wd !== 1'b1 || obs_ws[0] !== expv[t]) begin
        errors++;
        $display("FAIL window_case%0d wd=%b ws0=%b exp wd=1 ws0=%b", t, obs_wd, obs_ws[0], expv[t]);
      end
      checks++;
      if (obs_ws[N-1:1] !== '0) begin
        errors++;
        $display("FAIL window_idle_ch%0d ws=%b exp 0", t, obs_ws);
      end
    end
  endtask

  task automatic test_iaf();
    logic [4:0] pat;
    bus.en   = 1'b0;
    bus.mode = MODE_IAF;
    cycle('0);
    wr(2, 5);
    bus.threshold = AW'(12);
    bus.en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(N'(4));
      pat[k] = obs_ws[2];
    end
    checks++;
    if (pat !== 5'b10100) begin
      errors++;
      $display("FAIL iaf_pattern got=%b exp=10100", pat);
    end
  endtask

  task automatic test_write_collision();
    logic a;
    logic b;
    wr(1, 2);
    bus.threshold  = AW'(8);
    bus.en         = 1'b1;
    bus.wt_wr_en   = 1'b1;
    bus.wt_wr_addr = ADW'(1);
    bus.wt_wr_data = weight_t'(9);
    cycle(N'(2));
    a = obs_ws[1];
    bus.wt_wr_en = 1'b0;
    cycle(N'(2));
    b = obs_ws[1];
    checks++;
    if ({a, b} !== 2'b01) begin
      errors++;
      $display("FAIL collision got=%b%b exp=01", a, b);
    end
    bus.en   = 1'b0;
    bus.mode = MODE_WINDOW;
    cycle('0);
    bus.mode = MODE_IAF;
    cycle('0);
    wr(N, 200);
    bus.threshold = AW'(9);
    bus.en = 1'b1;
    cycle('1);
    checks++;
    if (obs_ws !== '0) begin
      errors++;
      $display("FAIL bad_addr_write ws=%b exp 000000", obs_ws);
    end
  endtask

  task automatic test_enable_mode();
    int found;
    bus.mode      = MODE_WINDOW;
    bus.en        = 1'b1;
    bus.threshold = AW'(20);
    cycle(N'(1));
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      bus.en = !(k >= 7 && k <= 11);
      cycle((k <= 11) ? N'(1) : N'(0));
      if (obs_wd) begin
        found = k;
        break;
      end
    end
    checks++;
    if (found != 21 || obs_ws[0] !== 1'b1) begin
      errors++;
      $display("FAIL enable_freeze done_at=%0d ws0=%b exp 21 ws0=1", found, obs_ws[0]);
    end
    bus.en = 1'b1;
    for (int k = 0; k < 8; k++) cycle(N'(1));
    bus.mode = MODE_IAF;
    cycle(N'(1));
    cycle(N'(1));
    checks++;
    if (obs_ws[0] !== 1'b0) begin
      errors++;
      $display("FAIL mode_toggle_clear ws0=%b exp 0", obs_ws[0]);
    end
    bus.mode = MODE_WINDOW;
    cycle('0);
    found = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle('0);
      if (obs_wd) begin
        found = k;
        break;
      end
    end
    checks++;
    if (found != 16) begin
      errors++;
      $display("FAIL mode_toggle_counter done_at=%0d exp 16", found);
    end
  endtask

  task automatic test_saturation();
    logic [2:0] e;
    logic [2:0] o;
    bus8.en         = 1'b0;
    bus8.wt_wr_en   = 1'b1;
    bus8.wt_wr_addr = 1'b0;
    bus8.wt_wr_data = weight_t'(255);
    @(posedge clk);
    #1;
    bus8.wt_wr_en  = 1'b0;
    bus8.threshold = 8'd254;
    bus8.en        = 1'b1;
    bus8.pre_spike = 2'b01;
    for (int k = 0; k < 16; k++) begin
      sb8.push_back((k == 15) ? 3'b011 : 3'b000);
      @(posedge clk);
      #1;
      e = sb8.pop_front();
      o = {bus8.weighted_spike, bus8.window_done};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL saturation k=%0d ws_wd=%b exp=%b", k, o, e);
      end
    end
    bus8.en = 1'b0;
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.en          = 1'b0;
    bus.mode        = MODE_WINDOW;
    bus.pre_spike   = '0;
    bus.threshold   = '0;
    bus.wt_wr_en    = 1'b0;
    bus.wt_wr_addr  = '0;
    bus.wt_wr_data  = '0;
    bus8.en         = 1'b0;
    bus8.mode       = MODE_WINDOW;
    bus8.pre_spike  = '0;
    bus8.threshold  = '0;
    bus8.wt_wr_en   = 1'b0;
    bus8.wt_wr_addr = '0;
    bus8.wt_wr_data = '0;
    model_reset();
    #1;
    test_reset();
    test_window_mode();
    test_iaf();
    test_write_collision();
    test_enable_mode();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
